// File: rtl/custom_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// custom_sync_fifo_if
//   Bundles the producer/consumer side of custom_sync_fifo into one port.
//
//   Handshake: a write is accepted on a rising edge when wen=1 and the
//   pre-edge fifo_full=0. A read is accepted on a rising edge when ren=1 and
//   the pre-edge fifo_empty=0. A rejected request is dropped and is not
//   retried. It only raises the sticky overflow/underflow flag. flush=1 on an
//   edge overrides both requests for that edge.
//
//   master : drives din/wen/ren/flush/clr_err, observes data and status
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface custom_sync_fifo_if #(
    parameter int DATADDRSIZE = 8,
    parameter int ADDRSIZE    = 4
);
    logic [DATADDRSIZE-1:0] din;
    logic                   wen;
    logic                   ren;
    logic                   flush;
    logic                   clr_err;
    logic [DATADDRSIZE-1:0] dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [ADDRSIZE:0]      fifo_count;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output din, wen, ren, flush, clr_err,
        input  dout, fifo_full, fifo_empty, almost_full, almost_empty,
               fifo_count, overflow, underflow
    );

    modport slave (
        input  din, wen, ren, flush, clr_err,
        output dout, fifo_full, fifo_empty, almost_full, almost_empty,
               fifo_count, overflow, underflow
    );
endinterface

// File: rtl/custom_sync_fifo.sv
// ---------------------------------------------------------------------------
// custom_sync_fifo
//   Single-clock FIFO of 2**ADDRSIZE words of DATADDRSIZE bits. The block has
//   a registered occupancy count and full/empty/almost flags decoded from it.
//   It also has sticky overflow/underflow flags, a synchronous flush, and
//   either a registered read (FWFT=0) or a first-word-fall-through read
//   (FWFT=1).
//
//   Ports:
//     clk_i  : clock, all state changes on the rising edge
//     rst_i  : asynchronous active-high reset
//     bus    : slave side of custom_sync_fifo_if
//              (din, wen, ren, flush, clr_err in; dout, status flags,
//               fifo_count, overflow, underflow out)
// ---------------------------------------------------------------------------
module custom_sync_fifo #(
    parameter int DATADDRSIZE     = 8,
    parameter int ADDRSIZE        = 4,
    parameter int ALMOST_FULL_TH  = 12,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int FWFT            = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    custom_sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE + 1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AF_C    = (ADDRSIZE + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDRSIZE:0] AE_C    = (ADDRSIZE + 1)'(ALMOST_EMPTY_TH);

    logic [DATADDRSIZE-1:0] mem_q [DEPTH];

    logic [ADDRSIZE-1:0]    wptr_q, wptr_d;
    logic [ADDRSIZE-1:0]    rptr_q, rptr_d;
    logic [ADDRSIZE:0]      count_q, count_d;
    logic [DATADDRSIZE-1:0] dout_q, dout_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    logic full_w, empty_w;
    logic wr_acc, rd_acc;
    logic ovf_set, udf_set;

    // Flags come from the registered count only, so they move on the same
    // edge as fifo_count and never glitch with the request inputs.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    assign wr_acc  = bus.wen && !full_w  && !bus.flush;
    assign rd_acc  = bus.ren && !empty_w && !bus.flush;

    // A flush cycle raises no error even if it sees a full or empty FIFO.
    assign ovf_set = bus.wen && full_w  && !bus.flush;
    assign udf_set = bus.ren && empty_w && !bus.flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            dout_d  = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + ADDRSIZE'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + ADDRSIZE'(1);
                dout_d = mem_q[rptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (ADDRSIZE + 1)'(1);
                2'b01:   count_d = count_q - (ADDRSIZE + 1)'(1);
                default: count_d = count_q;
            endcase
        end

        // In FWFT mode the output is taken straight from memory. The output
        // register then stays at zero.
        if (FWFT != 0) begin
            dout_d = '0;
        end

        // A set condition in the same cycle as clr_err takes priority.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (bus.clr_err) begin
            overflow_d = 1'b0;
        end

        if (udf_set) begin
            underflow_d = 1'b1;
        end else if (bus.clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= bus.din;
        end
    end

    assign bus.dout         = (FWFT != 0) ? (empty_w ? '0 : mem_q[rptr_q]) : dout_q;
    assign bus.fifo_full    = full_w;
    assign bus.fifo_empty   = empty_w;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.fifo_count   = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/custom_sync_fifo.md
# custom_sync_fifo

Single-clock, parametrised successor to the team's async FIFO. It buffers DATADDRSIZE-bit words in a 2**ADDRSIZE-deep memory and provides registered full/empty, programmable almost-full/almost-empty thresholds, and an occupancy count. It also has sticky overflow/underflow error flags, a synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode. It is used wherever producer and consumer share one clock domain.

## Interface

Parameters:

- DATADDRSIZE, 8, data word width in bits
- ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE
- ALMOST_FULL_TH, 12, almost_full asserts when fifo_count >= this value (range 1..DEPTH)
- ALMOST_EMPTY_TH, 2, almost_empty asserts when fifo_count <= this value (range 0..DEPTH-1)
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through

Ports:

- clk_i  input  1  sole clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- din  input  DATADDRSIZE  write data
- wen  input  1  write request
- ren  input  1  read request
- flush  input  1  synchronous clear of contents
- clr_err  input  1  synchronous clear of overflow/underflow
- dout  output  DATADDRSIZE  read data
- fifo_full  output  1  fifo_count == DEPTH
- fifo_empty  output  1  fifo_count == 0
- almost_full  output  1  fifo_count >= ALMOST_FULL_TH
- almost_empty  output  1  fifo_count <= ALMOST_EMPTY_TH
- fifo_count  output  ADDRSIZE+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was attempted while full
- underflow  output  1  sticky: a read was attempted while empty

## Operation

- **Reset (rst_i=1, asynchronous).**
  - Write/read pointers reset to 0 and fifo_count to 0.
  - dout resets to 0, overflow to 0, underflow to 0.
  - Outputs after reset: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- **Pointers.** Write and read pointers are ADDRSIZE bits wide and wrap modulo DEPTH. Occupancy is tracked by fifo_count, not by pointer comparison.
- **Write accept.** A write is accepted when wen && !fifo_full, evaluated on the pre-edge value of fifo_full. On accept: mem[wptr] <= din, then wptr increments.
- **Read accept.** A read is accepted when ren && !fifo_empty, evaluated on the pre-edge value of fifo_empty. On accept, rptr increments.
- **Simultaneous write and read.**
  - Each request is judged independently against the pre-edge flags.
  - Both accepted: fifo_count is unchanged.
  - When full, the read is accepted and the write is rejected.
  - When empty, the write is accepted and the read is rejected.
- **fifo_count.** Next value is count + wacc − racc. It never exceeds DEPTH and never goes below 0.
- **Flags.** All of fifo_full, fifo_empty, almost_full and almost_empty are decoded from the registered fifo_count, so they change on the same edge as the count.
- **Error flags.**
  - overflow is set on any edge where wen && fifo_full.
  - underflow is set on any edge where ren && fifo_empty.
  - Both flags hold until clr_err or rst_i.
  - If a set condition and clr_err occur in the same cycle, set wins.
- **Flush.**
  - On an edge with flush=1: pointers and fifo_count go to 0; wen and ren that cycle are ignored.
  - In standard mode, dout goes to 0.
  - overflow and underflow are unaffected, and no error is raised by that cycle's wen/ren.
- **Standard mode (FWFT=0).**
  - dout is a register loaded with mem[rptr] on an accepted read.
  - dout holds its value otherwise, including while empty.
- **FWFT mode (FWFT=1).**
  - dout = fifo_empty ? 0 : mem[rptr], with no register stage; the head word is visible whenever fifo_empty=0.
  - ren acknowledges (pops) the displayed word.

## Timing

- Write accepted at edge N:
  - fifo_count and flags reflect it immediately after edge N.
  - In FWFT mode, the word appears on dout after edge N if the FIFO was empty.
- Standard-mode read latency: ren accepted at edge M means the popped word is on dout after edge M (one cycle from request).
- FWFT read: the head word is valid before the ren edge; after edge M, dout shows the next word, or 0 if the FIFO became empty.
- Full throughput: one write and one read per cycle, sustained.
- Reset mid-operation:
  - All outputs reach their reset values asynchronously, without waiting for a clock edge.
  - The first accepted operation is on the first rising edge after rst_i deasserts.

## Test plan

All scenarios use DATADDRSIZE=8, ADDRSIZE=4 (DEPTH=16), ALMOST_FULL_TH=12, ALMOST_EMPTY_TH=2.

- **Fill/drain, FWFT=0.**
  - Stimulus: write 0x00..0x0F, then read 16 times.
  - Required: fifo_count 12 gives almost_full=1; count 16 gives fifo_full=1. dout sequence is 0x00..0x0F, each word one cycle after its ren. almost_empty=1 at count 2. Final fifo_empty=1.
- **Overflow/underflow.**
  - Stimulus: at count 16, wen with din=0xAA; then drain fully and assert ren once more; then pulse clr_err.
  - Required: overflow=1 and count stays 16; 0xAA is never read; underflow=1 after the extra ren; both flags return to 0 one edge after clr_err.
- **Simultaneous read and write.**
  - Full case: at count 16, wen=ren=1 for one cycle. Required: count becomes 15, overflow=1, dout = oldest word.
  - Empty case: at count 0, same stimulus. Required: count becomes 1, underflow=1.
  - Steady case: at count 5, wen=ren=1 for 40 cycles. Required: count stays 5 and data order is preserved across pointer wrap.
- **FWFT=1.**
  - Stimulus: write 0x5A into an empty FIFO.
  - Required: after that edge, fifo_empty=0 and dout=0x5A with no ren. After an ren edge, dout=0 and fifo_empty=1.
- **Flush and reset.**
  - Flush stimulus: at count 9 with overflow=1, assert flush with wen=ren=1. Required: count=0, fifo_empty=1, overflow still 1.
  - Reset stimulus: assert rst_i between clock edges. Required: all outputs at their reset values immediately.
- **Random scoreboard.**
  - Stimulus: 2000 cycles of random wen/ren/din in both FWFT modes, checked against a queue model.
  - Required: zero data mismatches, and fifo_count always equals the model's depth.
